// File: rtl/nios_led3_cpu_ocimem_arbiter.sv
// nios_led3_cpu_ocimem_arbiter
// Shares the single-port OCI debug RAM between the CPU debug-memory Avalon
// slave and the JTAG debug command path. JTAG reads are returned in MonDReg.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | arbitrate between CPU request and pending JTAG command
// ST_CPU_RD  | RAM data for the granted CPU read is on i_ram_rdata
// ST_JTAG_RD | RAM data for the granted JTAG read is on i_ram_rdata
module nios_led3_cpu_ocimem_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [37:0]       i_jdo,
    input  logic              i_take_action_ocimem_a,
    input  logic              i_take_no_action_ocimem_a,
    input  logic              i_take_action_ocimem_b,
    input  logic [ADDR_W-1:0] i_av_address,
    input  logic              i_av_read,
    input  logic              i_av_write,
    input  logic [31:0]       i_av_writedata,
    input  logic [3:0]        i_av_byteenable,
    output logic              o_av_waitrequest,
    output logic [31:0]       o_av_readdata,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_wren,
    output logic [3:0]        o_ram_byteen,
    output logic [31:0]       o_ram_wdata,
    input  logic [31:0]       i_ram_rdata,
    output logic [31:0]       o_mon_dreg,
    output logic              o_jtag_busy,
    output logic              o_jtag_overrun
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CPU_RD  = 2'd1,
        ST_JTAG_RD = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_jaddr;
    logic                r_jpend;
    logic                r_jwr;
    logic [31:0]         r_jdata;
    logic                r_last_grant;   // 0 = CPU, 1 = JTAG
    logic [31:0]         r_mon_dreg;
    logic                r_overrun;

    logic                w_in_idle;
    logic                w_cpu_req;
    logic                w_grant_jtag;
    logic                w_grant_cpu;
    logic                w_jtag_busy;
    logic                w_strobe;
    logic [ADDR_W-1:0]   w_jdo_addr;
    logic [31:0]         w_jdo_data;
    logic                w_jdo_rd;
    logic                w_unused_jdo;

    assign w_jdo_addr   = i_jdo[ADDR_W+16:17];
    assign w_jdo_data   = i_jdo[34:3];
    assign w_jdo_rd     = i_jdo[34];
    assign w_unused_jdo = ^{i_jdo[37:35], i_jdo[2:0]};

    // Reset gates the grants so no RAM write can slip out while in reset.
    assign w_in_idle    = (r_state == ST_IDLE) & ~i_reset;
    assign w_cpu_req    = i_av_read | i_av_write;
    // On a tie the requester that did not win last time gets the RAM.
    assign w_grant_jtag = w_in_idle & r_jpend & (~w_cpu_req | ~r_last_grant);
    assign w_grant_cpu  = w_in_idle & w_cpu_req & (~r_jpend | r_last_grant);

    assign w_jtag_busy  = r_jpend | (r_state == ST_JTAG_RD);
    assign w_strobe     = i_take_action_ocimem_a | i_take_no_action_ocimem_a
                        | i_take_action_ocimem_b;

    assign o_av_readdata  = i_ram_rdata;
    assign o_mon_dreg     = r_mon_dreg;
    assign o_jtag_busy    = w_jtag_busy;
    assign o_jtag_overrun = r_overrun;

    // RAM port mux and Avalon handshake for the grant of the current cycle
    always_comb begin
        o_ram_addr       = i_av_address;
        o_ram_wdata      = i_av_writedata;
        o_ram_byteen     = i_av_byteenable;
        o_ram_wren       = 1'b0;
        o_av_waitrequest = 1'b1;
        if (i_reset) begin
            o_ram_addr   = '0;
            o_ram_byteen = '0;
        end else if (w_grant_jtag) begin
            o_ram_addr   = r_jaddr;
            o_ram_wdata  = r_jdata;
            o_ram_byteen = 4'hF;
            o_ram_wren   = r_jwr;
        end else if (w_grant_cpu) begin
            if (i_av_write) begin
                o_ram_wren       = 1'b1;
                o_av_waitrequest = 1'b0;
            end
        end else if (r_state == ST_CPU_RD) begin
            o_av_waitrequest = 1'b0;
        end
    end

    // Arbitration FSM, JTAG command capture and MonDReg update
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_jaddr      <= '0;
            r_jpend      <= 1'b0;
            r_jwr        <= 1'b0;
            r_jdata      <= '0;
            r_last_grant <= 1'b1;
            r_mon_dreg   <= '0;
            r_overrun    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_jtag) begin
                        r_last_grant <= 1'b1;
                        r_jpend      <= 1'b0;
                        if (r_jwr) begin
                            r_jaddr <= r_jaddr + 1'b1;
                        end else begin
                            r_state <= ST_JTAG_RD;
                        end
                    end else if (w_grant_cpu) begin
                        r_last_grant <= 1'b0;
                        if (!i_av_write) begin
                            r_state <= ST_CPU_RD;
                        end
                    end
                end
                ST_CPU_RD: begin
                    r_state <= ST_IDLE;
                end
                ST_JTAG_RD: begin
                    r_mon_dreg <= i_ram_rdata;
                    r_jaddr    <= r_jaddr + 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // A strobe is only accepted when nothing is pending or in flight,
            // so it never collides with the jaddr/jpend updates above.
            if (w_strobe) begin
                if (w_jtag_busy) begin
                    r_overrun <= 1'b1;
                end else if (i_take_action_ocimem_b) begin
                    r_jpend <= 1'b1;
                    r_jwr   <= 1'b1;
                    r_jdata <= w_jdo_data;
                end else if (i_take_action_ocimem_a) begin
                    r_jaddr <= w_jdo_addr;
                    if (w_jdo_rd) begin
                        r_jpend <= 1'b1;
                        r_jwr   <= 1'b0;
                    end
                end else begin
                    r_jpend <= 1'b1;
                    r_jwr   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_nios_led3_cpu_ocimem_arbiter.sv
// Testbench for nios_led3_cpu_ocimem_arbiter: table of CPU transfers, directed
// JTAG/contention/reset sequences, then concurrent random CPU and JTAG traffic
// checked against a transaction-level memory model.
module tb_nios_led3_cpu_ocimem_arbiter;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [37:0]   jdo = '0;
    logic          ta_a = 1'b0, tna_a = 1'b0, ta_b = 1'b0;
    logic [AW-1:0] av_address = '0;
    logic          av_read = 1'b0, av_write = 1'b0;
    logic [31:0]   av_writedata = '0;
    logic [3:0]    av_byteenable = '0;
    logic          av_waitrequest;
    logic [31:0]   av_readdata;
    logic [AW-1:0] ram_addr;
    logic          ram_wren;
    logic [3:0]    ram_byteen;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata = '0;
    logic [31:0]   mondreg;
    logic          jtag_busy, jtag_overrun;

    logic [31:0]   mem [256];
    logic [31:0]   ref_mem [256];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nios_led3_cpu_ocimem_arbiter #(.ADDR_W(AW)) dut (
        .i_clk                     (clk),
        .i_reset                   (rst),
        .i_jdo                     (jdo),
        .i_take_action_ocimem_a    (ta_a),
        .i_take_no_action_ocimem_a (tna_a),
        .i_take_action_ocimem_b    (ta_b),
        .i_av_address              (av_address),
        .i_av_read                 (av_read),
        .i_av_write                (av_write),
        .i_av_writedata            (av_writedata),
        .i_av_byteenable           (av_byteenable),
        .o_av_waitrequest          (av_waitrequest),
        .o_av_readdata             (av_readdata),
        .o_ram_addr                (ram_addr),
        .o_ram_wren                (ram_wren),
        .o_ram_byteen              (ram_byteen),
        .o_ram_wdata               (ram_wdata),
        .i_ram_rdata               (ram_rdata),
        .o_mon_dreg                (mondreg),
        .o_jtag_busy               (jtag_busy),
        .o_jtag_overrun            (jtag_overrun)
    );

    // Single-port RAM with one cycle of registered read latency
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        if (ram_wren) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_byteen[b]) mem[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    function automatic logic [37:0] jdo_addr(input logic [AW-1:0] a, input logic rd);
        logic [37:0] v;
        v = '0;
        v[AW+16:17] = a;
        v[34] = rd;
        return v;
    endfunction

    function automatic logic [37:0] jdo_data(input logic [31:0] d);
        logic [37:0] v;
        v = '0;
        v[34:3] = d;
        return v;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~m) | (nw & m);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_max(input string name, input int act, input int lim);
        n_tests++;
        if (act > lim) begin
            n_fail++;
            $display("FAIL %s: got %0d, required at most %0d", name, act, lim);
        end
    endtask

    // kind: 0 = ocimem_a, 1 = no_action ocimem_a, 2 = ocimem_b
    task automatic jtag_cmd(input int kind, input logic [37:0] d);
        @(posedge clk); #1;
        jdo   = d;
        ta_a  = (kind == 0);
        tna_a = (kind == 1);
        ta_b  = (kind == 2);
        @(posedge clk); #1;
        ta_a  = 1'b0;
        tna_a = 1'b0;
        ta_b  = 1'b0;
    endtask

    task automatic wait_jtag_idle(output int busy_cycles);
        bit idle;
        idle = 1'b0;
        busy_cycles = 0;
        while (!idle && busy_cycles < 20) begin
            @(negedge clk);
            if (!jtag_busy) idle = 1'b1;
            else busy_cycles++;
        end
        if (!idle) begin
            n_tests++;
            n_fail++;
            $display("FAIL jtag_busy_timeout: busy for %0d cycles, required to clear", busy_cycles);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting cycle.
    task automatic cpu_xfer(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                            input logic [3:0] be, output logic [31:0] rd, output int waits);
        bit done;
        done          = 1'b0;
        waits         = 0;
        rd            = '0;
        av_address    = a;
        av_write      = wr;
        av_read       = ~wr;
        av_writedata  = d;
        av_byteenable = be;
        while (!done && waits < 20) begin
            @(negedge clk);
            if (!av_waitrequest) begin
                done = 1'b1;
                rd   = av_readdata;
            end else begin
                waits++;
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL cpu_timeout: waitrequest high for %0d cycles at addr %h", waits, a);
        end
        @(posedge clk); #1;
    endtask

    task automatic cpu_idle();
        av_read  = 1'b0;
        av_write = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        int          exp_waits;
    } vec_t;

    vec_t vt[11];

    initial begin
        logic [31:0] rd;
        int w, bc;

        vt[0]  = '{1'b1, 8'h05, 32'h1122_3344, 4'hF, 32'h0,         0};
        vt[1]  = '{1'b0, 8'h05, 32'h0,         4'h0, 32'h1122_3344, 1};
        vt[2]  = '{1'b1, 8'h06, 32'hAABB_CCDD, 4'h1, 32'h0,         0};
        vt[3]  = '{1'b0, 8'h06, 32'h0,         4'h0, 32'hC0FF_EEDD, 1};
        vt[4]  = '{1'b1, 8'h07, 32'h5566_7788, 4'hC, 32'h0,         0};
        vt[5]  = '{1'b0, 8'h07, 32'h0,         4'h0, 32'h5566_EE07, 1};
        vt[6]  = '{1'b1, 8'hFF, 32'h0BAD_F00D, 4'hA, 32'h0,         0};
        vt[7]  = '{1'b0, 8'hFF, 32'h0,         4'h0, 32'h0BFF_F0FF, 1};
        vt[8]  = '{1'b0, 8'h00, 32'h0,         4'h0, 32'hC0FF_EE00, 1};
        vt[9]  = '{1'b1, 8'h08, 32'h0000_0000, 4'h0, 32'h0,         0};
        vt[10] = '{1'b0, 8'h08, 32'h0,         4'h0, 32'hC0FF_EE08, 1};

        for (int i = 0; i < 256; i++) mem[i] = {24'hC0FFEE, i[7:0]};
        mem[8'h10] = 32'hDEAD_BEEF;

        // Reset values, with a CPU write held during reset to show it is gated
        #2;
        rst           = 1'b1;
        av_write      = 1'b1;
        av_address    = 8'h33;
        av_byteenable = 4'hF;
        @(negedge clk);
        check("rst_waitrequest", av_waitrequest, 1'b1);
        check("rst_wren", ram_wren, 1'b0);
        check("rst_ram_addr", ram_addr, 8'h00);
        check("rst_byteen", ram_byteen, 4'h0);
        check("rst_mondreg", mondreg, 32'h0);
        check("rst_busy", jtag_busy, 1'b0);
        check("rst_overrun", jtag_overrun, 1'b0);
        check("rst_readdata_passthru", av_readdata, ram_rdata);
        av_write      = 1'b0;
        av_byteenable = 4'h0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Table of uncontended CPU transfers
        for (int i = 0; i < 11; i++) begin
            cpu_xfer(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].be, rd, w);
            check($sformatf("vec%0d_waits", i), w, vt[i].exp_waits);
            if (!vt[i].wr) check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
        end
        cpu_idle();

        // JTAG address load with read
        jtag_cmd(0, jdo_addr(8'h10, 1'b1));
        wait_jtag_idle(bc);
        check("jrd_busy_cycles", bc, 2);
        check("jrd_mondreg", mondreg, 32'hDEAD_BEEF);
        jtag_cmd(1, '0);
        wait_jtag_idle(bc);
        check("jrd_stream_next_addr", mondreg, 32'hC0FF_EE11);

        // JTAG writes across the address wrap
        jtag_cmd(0, jdo_addr(8'hFE, 1'b0));
        wait_jtag_idle(bc);
        check("jload_no_read_busy", bc, 0);
        for (int k = 1; k <= 3; k++) begin
            jtag_cmd(2, jdo_data(k));
            wait_jtag_idle(bc);
            check("jwr_busy_cycles", bc, 1);
        end
        check("jwr_mem_fe", mem[8'hFE], 32'd1);
        check("jwr_mem_ff", mem[8'hFF], 32'd2);
        check("jwr_mem_00_wrap", mem[8'h00], 32'd3);

        // First tie after reset goes to the CPU, JTAG read follows
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        jtag_cmd(0, jdo_addr(8'h12, 1'b1));
        cpu_xfer(1'b0, 8'h06, 32'h0, 4'h0, rd, w);
        check("tie_cpu_waits", w, 1);
        check("tie_cpu_rdata", rd, 32'hC0FF_EEDD);
        cpu_idle();
        wait_jtag_idle(bc);
        check("tie_jtag_busy_after_cpu", bc, 2);
        check("tie_jtag_mondreg", mondreg, 32'hC0FF_EE12);

        // Continuous CPU writes with one JTAG write folded in
        jtag_cmd(0, jdo_addr(8'h40, 1'b0));
        wait_jtag_idle(bc);
        @(posedge clk); #1;
        fork
            jtag_cmd(2, jdo_data(32'hFACE_0001));
        join_none
        for (int k = 0; k < 6; k++) begin
            cpu_xfer(1'b1, 8'h20 + 8'(k), {16'h5A5A, 8'hB0, 8'(k)}, 4'b0011, rd, w);
            check($sformatf("stream_wr%0d_waits", k), w, (k == 2) ? 1 : 0);
        end
        cpu_idle();
        wait_jtag_idle(bc);
        for (int k = 0; k < 6; k++)
            check($sformatf("stream_mem_%0d", k), mem[8'h20 + 8'(k)], {16'hC0FF, 8'hB0, 8'(k)});
        check("stream_jtag_mem", mem[8'h40], 32'hFACE_0001);

        // Strobes while busy are dropped and flagged
        jtag_cmd(0, jdo_addr(8'h30, 1'b1));
        jdo  = jdo_data(32'h1357_9BDF);
        ta_b = 1'b1;
        @(posedge clk); #1;
        ta_b = 1'b0;
        jdo  = jdo_addr(8'h50, 1'b1);
        ta_a = 1'b1;
        @(posedge clk); #1;
        ta_a = 1'b0;
        wait_jtag_idle(bc);
        check("ovr_flag", jtag_overrun, 1'b1);
        check("ovr_first_completes", mondreg, 32'hC0FF_EE30);
        check("ovr_no_write", mem[8'h31], 32'hC0FF_EE31);
        jtag_cmd(1, '0);
        wait_jtag_idle(bc);
        check("ovr_jaddr_kept", mondreg, 32'hC0FF_EE31);
        check("ovr_sticky", jtag_overrun, 1'b1);

        // Reset during CPU_RD with a JTAG write pending
        jtag_cmd(0, jdo_addr(8'h60, 1'b0));
        wait_jtag_idle(bc);
        @(posedge clk); #1;
        jdo        = jdo_data(32'h0BAD_0BAD);
        ta_b       = 1'b1;
        av_address = 8'h07;
        av_read    = 1'b1;
        @(posedge clk); #1;
        ta_b = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("rstmid_waitrequest", av_waitrequest, 1'b1);
        check("rstmid_busy", jtag_busy, 1'b0);
        @(negedge clk);
        check("rstmid_wren", ram_wren, 1'b0);
        check("rstmid_overrun_cleared", jtag_overrun, 1'b0);
        cpu_idle();
        @(posedge clk); #1;
        rst = 1'b0;
        cpu_xfer(1'b0, 8'h07, 32'h0, 4'h0, rd, w);
        check("rstmid_post_rdata", rd, 32'h5566_EE07);
        check("rstmid_post_waits", w, 1);
        cpu_idle();
        repeat (3) @(negedge clk);
        check("rstmid_jwr_dropped", mem[8'h60], 32'hC0FF_EE60);
        check("rstmid_busy_after", jtag_busy, 1'b0);

        // Random concurrent traffic: CPU on 0x00-0x7F, JTAG on 0x80-0xFF
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        fork
            begin : cpu_p
                logic        c_wr;
                logic [7:0]  c_a;
                logic [31:0] c_d, c_rd;
                logic [3:0]  c_be;
                int          c_w, c_gap;
                for (int t = 0; t < 150; t++) begin
                    c_wr = 1'($urandom_range(0, 1));
                    c_a  = 8'($urandom_range(0, 127));
                    c_d  = $urandom;
                    c_be = 4'($urandom_range(0, 15));
                    cpu_xfer(c_wr, c_a, c_d, c_be, c_rd, c_w);
                    if (c_wr) begin
                        ref_mem[c_a] = merge(ref_mem[c_a], c_d, c_be);
                        check_max("rnd_cpu_wr_waits", c_w, 2);
                    end else begin
                        check($sformatf("rnd_cpu_rd_%h", c_a), c_rd, ref_mem[c_a]);
                        check_max("rnd_cpu_rd_waits", c_w, 3);
                    end
                    cpu_idle();
                    c_gap = $urandom_range(0, 2);
                    repeat (c_gap) begin
                        @(posedge clk); #1;
                    end
                end
            end
            begin : jtag_p
                logic [7:0]  ja;
                logic [31:0] j_d;
                logic        j_rd;
                int          j_op, j_bc;
                ja = 8'h80;
                jtag_cmd(0, jdo_addr(ja, 1'b0));
                wait_jtag_idle(j_bc);
                for (int t = 0; t < 50; t++) begin
                    j_op = $urandom_range(0, 3);
                    if (ja > 8'hF0) j_op = 0;
                    if (j_op == 0) begin
                        ja   = 8'($urandom_range(128, 224));
                        j_rd = 1'($urandom_range(0, 1));
                        jtag_cmd(0, jdo_addr(ja, j_rd));
                        wait_jtag_idle(j_bc);
                        if (j_rd) begin
                            check($sformatf("rnd_jtag_ld_rd_%h", ja), mondreg, ref_mem[ja]);
                            check_max("rnd_jtag_rd_busy", j_bc, 4);
                            ja = ja + 8'd1;
                        end
                    end else if (j_op == 1) begin
                        jtag_cmd(1, '0);
                        wait_jtag_idle(j_bc);
                        check($sformatf("rnd_jtag_rd_%h", ja), mondreg, ref_mem[ja]);
                        check_max("rnd_jtag_rd_busy", j_bc, 4);
                        ja = ja + 8'd1;
                    end else begin
                        j_d         = $urandom;
                        ref_mem[ja] = j_d;
                        jtag_cmd(2, jdo_data(j_d));
                        wait_jtag_idle(j_bc);
                        check_max("rnd_jtag_wr_busy", j_bc, 3);
                        ja = ja + 8'd1;
                    end
                end
            end
        join

        repeat (2) @(negedge clk);
        check("rnd_no_overrun", jtag_overrun, 1'b0);
        for (int i = 0; i < 256; i++)
            check($sformatf("rnd_mem[%0d]", i), mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
